rotor_stage: RTL
================

// Module: rotor_stage
// PURPOSE
//   Parametrised, clocked Enigma rotor. Holds its own rotational position and steps on command.
//   Translates symbols in forward (keyboard->reflector) or reverse (reflector->lamp) direction with
//   correct offset arithmetic, and emits a turnover carry to drive the next rotor's step.
//   Sits in the rotor chain between the plugboard and the reflector; instantiated once per rotor.
// PARAMETERS
//   N_SYM     26  alphabet size; symbols encoded 1..N_SYM, 0 = no/invalid symbol
//   SYM_W     5   symbol/position width; must satisfy 2**SYM_W > N_SYM
//   ROTOR_ID  1   wiring table selected from enigma_pkg (1..3)
//   NOTCH     16  position (0-based) whose departure produces a carry
// PORTS
//   clk        in   1      system clock, all state on rising edge
//   rst        in   1      synchronous, active-high reset
//   load       in   1      load start position from load_pos
//   load_pos   in   SYM_W  start position 0..N_SYM-1
//   step       in   1      single-cycle pulse: advance position by one
//   in_valid   in   1      in_sym/dir are valid this cycle
//   in_sym     in   SYM_W  symbol to translate, 1..N_SYM
//   dir        in   1      0 = forward table, 1 = inverse table
//   out_valid  out  1      out_sym/out_err valid (one-cycle pulse)
//   out_sym    out  SYM_W  translated symbol, 1..N_SYM; 0 on error
//   out_err    out  1      in_sym was 0 or >N_SYM
//   pos        out  SYM_W  current position 0..N_SYM-1
//   carry_out  out  1      one-cycle pulse: rotor stepped off NOTCH
// BEHAVIOUR
//   Reset: pos=0, out_valid=0, out_sym=0, out_err=0, carry_out=0.
//   Position update priority: rst > load > step. load with load_pos>=N_SYM loads 0.
//   step: pos <= (pos==N_SYM-1) ? 0 : pos+1. carry_out registered, high the cycle after the edge
//     on which pos moved NOTCH->NOTCH+1 (or wrap if NOTCH==N_SYM-1). load never raises carry_out.
//   Translation, latency 1: in_valid at edge k -> out_valid high in cycle k+1, for one cycle.
//     idx = (in_sym-1 + pos) mod N_SYM; t = TABLE[idx] (0-based, fwd or inverse per dir);
//     out_sym = ((t - pos) mod N_SYM) + 1. Mod computed on SYM_W+1 bits, no % operator on >N range.
//   Simultaneous in_valid and step/load: translation uses the pre-update pos (value before the edge).
//   Invalid in_sym: out_valid=1, out_err=1, out_sym=0; pos unaffected.
//   in_valid=0: out_valid=0 next cycle; out_sym/out_err hold their last values.
//   Back-to-back in_valid every cycle: full throughput, one result per cycle.
//   rst asserted mid-operation: pending result is discarded (out_valid=0 next cycle), pos=0.
//   Forward then reverse at the same pos must round-trip: rev(fwd(x))==x for all x, pos.
// STRUCTURE
//   enigma_pkg: N_SYM, SYM_W, wiring tables ROTOR1..3 forward and inverse (0-based),
//     notch constants per rotor, SYM_NONE=0.
//   Sub-module rotor_wiring: combinational ROM (ROTOR_ID, dir, idx) -> t.
//   rotor_stage holds position counter, carry register, output register, and offset adders.
// TESTING
//   1. rst, ROTOR_ID=1, pos=0, fwd in_sym=1 -> next cycle out_valid=1, out_sym=16.
//   2. one step (pos=1), fwd in_sym=1 -> out_sym=24; rev in_sym=24 -> out_sym=1.
//   3. load load_pos=25, step -> pos=0, carry_out=0; load 16, step -> pos=17, carry_out=1 one cycle.
//   4. in_valid and step same edge at pos=0, in_sym=1 -> out_sym=16 (pre-step pos), pos=1.
//   5. in_sym=0 and in_sym=27 -> out_err=1, out_sym=0; pos unchanged.
//   6. exhaustive: every pos 0..25, every x 1..26 -> rev(fwd(x))==x; rst mid-stream -> out_valid=0, pos=0.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared constants and rotor wiring tables for the Enigma rotor chain.
// Tables are 0-based: FWD[i] is the contact reached from contact i, INV is its inverse.
package enigma_pkg;

  localparam int N_SYM = 26;
  localparam int SYM_W = 5;
  localparam logic [SYM_W-1:0] SYM_NONE = 5'd0;

  localparam int NOTCH1 = 16;
  localparam int NOTCH2 = 4;
  localparam int NOTCH3 = 21;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_e;

  typedef logic [SYM_W-1:0] table_t [N_SYM];

  localparam table_t ROTOR1_FWD = '{
    5'd15, 5'd24, 5'd3,  5'd10, 5'd21, 5'd0,  5'd18, 5'd7,  5'd25, 5'd12, 5'd5,  5'd20, 5'd1,
    5'd8,  5'd22, 5'd17, 5'd2,  5'd11, 5'd19, 5'd6,  5'd13, 5'd4,  5'd23, 5'd9,  5'd14, 5'd16};
  localparam table_t ROTOR1_INV = '{
    5'd5,  5'd12, 5'd16, 5'd2,  5'd21, 5'd10, 5'd19, 5'd7,  5'd13, 5'd23, 5'd3,  5'd17, 5'd9,
    5'd20, 5'd24, 5'd0,  5'd25, 5'd15, 5'd6,  5'd18, 5'd11, 5'd4,  5'd14, 5'd22, 5'd1,  5'd8};

  localparam table_t ROTOR2_FWD = '{
    5'd0,  5'd9,  5'd3,  5'd10, 5'd18, 5'd8,  5'd17, 5'd20, 5'd23, 5'd1,  5'd11, 5'd7,  5'd22,
    5'd19, 5'd12, 5'd2,  5'd16, 5'd6,  5'd25, 5'd13, 5'd15, 5'd24, 5'd5,  5'd21, 5'd14, 5'd4};
  localparam table_t ROTOR2_INV = '{
    5'd0,  5'd9,  5'd15, 5'd2,  5'd25, 5'd22, 5'd17, 5'd11, 5'd5,  5'd1,  5'd3,  5'd10, 5'd14,
    5'd19, 5'd24, 5'd20, 5'd16, 5'd6,  5'd4,  5'd13, 5'd7,  5'd23, 5'd12, 5'd8,  5'd21, 5'd18};

  localparam table_t ROTOR3_FWD = '{
    5'd1,  5'd3,  5'd5,  5'd7,  5'd9,  5'd11, 5'd2,  5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
    5'd13, 5'd24, 5'd4,  5'd8,  5'd22, 5'd6,  5'd0,  5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14};
  localparam table_t ROTOR3_INV = '{
    5'd19, 5'd0,  5'd6,  5'd1,  5'd15, 5'd2,  5'd18, 5'd3,  5'd16, 5'd4,  5'd20, 5'd5,  5'd21,
    5'd13, 5'd25, 5'd7,  5'd24, 5'd8,  5'd23, 5'd9,  5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12};

endpackage

// File: rtl/rotor_stage_if.sv
// Control, translation and status bundle of one rotor stage.
interface rotor_stage_if #(
  parameter int SYM_W = enigma_pkg::SYM_W
);

  logic             load;
  logic [SYM_W-1:0] load_pos;
  logic             step;
  logic             in_valid;
  logic [SYM_W-1:0] in_sym;
  logic             dir;
  logic             out_valid;
  logic [SYM_W-1:0] out_sym;
  logic             out_err;
  logic [SYM_W-1:0] pos;
  logic             carry_out;

  modport master (
    output load, load_pos, step, in_valid, in_sym, dir,
    input  out_valid, out_sym, out_err, pos, carry_out
  );

  modport slave (
    input  load, load_pos, step, in_valid, in_sym, dir,
    output out_valid, out_sym, out_err, pos, carry_out
  );

endinterface

// File: rtl/rotor_wiring.sv
// Combinational wiring ROM: contact index -> contact index for the selected rotor.
module rotor_wiring import enigma_pkg::*; #(
  parameter int ROTOR_ID = 1
) (
  input  logic             dir_i,
  input  logic [SYM_W-1:0] idx_i,
  output logic [SYM_W-1:0] t_o
);

  // Table lookup; indices beyond the alphabet read as contact 0
  always_comb begin
    t_o = SYM_NONE;
    if (idx_i < SYM_W'(N_SYM)) begin
      case (ROTOR_ID)
        32'd2:   t_o = (dir_e'(dir_i) == DIR_REV) ? ROTOR2_INV[idx_i] : ROTOR2_FWD[idx_i];
        32'd3:   t_o = (dir_e'(dir_i) == DIR_REV) ? ROTOR3_INV[idx_i] : ROTOR3_FWD[idx_i];
        default: t_o = (dir_e'(dir_i) == DIR_REV) ? ROTOR1_INV[idx_i] : ROTOR1_FWD[idx_i];
      endcase
    end else begin
      t_o = SYM_NONE;
    end
  end

endmodule

// File: rtl/rotor_stage.sv
// One clocked Enigma rotor: position counter, turnover carry and a registered
// offset-corrected translation through the wiring ROM.
module rotor_stage #(
  parameter int N_SYM    = 26,
  parameter int SYM_W    = 5,
  parameter int ROTOR_ID = 1,
  parameter int NOTCH    = 16
) (
  input  logic         clk,
  input  logic         rst,
  rotor_stage_if.slave bus
);

  import enigma_pkg::*;

  localparam logic [SYM_W:0]   N_EXT     = (SYM_W+1)'(N_SYM);
  localparam logic [SYM_W-1:0] LAST_POS  = SYM_W'(N_SYM - 1);
  localparam logic [SYM_W-1:0] NOTCH_POS = SYM_W'(NOTCH);

  logic [SYM_W-1:0] pos_q, pos_d;
  logic             carry_q, carry_d;
  logic             out_valid_q, out_valid_d;
  logic [SYM_W-1:0] out_sym_q, out_sym_d;
  logic             out_err_q, out_err_d;

  logic [SYM_W:0]   idx_sum, idx_mod, back_sum, back_mod;
  logic [SYM_W-1:0] idx, t_val, rel_sym;
  logic             sym_bad;

  // Entry offset: rotate the input contact by the current position
  always_comb begin
    idx_sum = {1'b0, bus.in_sym} + {1'b0, pos_q} - (SYM_W+1)'(1);
    if (idx_sum >= N_EXT) begin
      idx_mod = idx_sum - N_EXT;
    end else begin
      idx_mod = idx_sum;
    end
    idx     = idx_mod[SYM_W-1:0];
    sym_bad = (bus.in_sym == SYM_NONE) || (bus.in_sym > SYM_W'(N_SYM));
  end

  rotor_wiring #(.ROTOR_ID(ROTOR_ID)) u_wiring (
    .dir_i (bus.dir),
    .idx_i (idx),
    .t_o   (t_val)
  );

  // Exit offset: undo the rotation, adding N first so the subtraction never goes negative
  always_comb begin
    back_sum = {1'b0, t_val} + N_EXT - {1'b0, pos_q};
    if (back_sum >= N_EXT) begin
      back_mod = back_sum - N_EXT;
    end else begin
      back_mod = back_sum;
    end
    rel_sym = back_mod[SYM_W-1:0] + SYM_W'(1);
  end

  // Next-state: load beats step; only a step off the notch raises carry
  always_comb begin
    pos_d       = pos_q;
    carry_d     = 1'b0;
    out_valid_d = bus.in_valid;
    out_sym_d   = out_sym_q;
    out_err_d   = out_err_q;
    if (bus.load) begin
      pos_d = (bus.load_pos >= SYM_W'(N_SYM)) ? SYM_W'(0) : bus.load_pos;
    end else if (bus.step) begin
      pos_d   = (pos_q == LAST_POS) ? SYM_W'(0) : pos_q + SYM_W'(1);
      carry_d = (pos_q == NOTCH_POS);
    end else begin
      pos_d = pos_q;
    end
    if (bus.in_valid) begin
      out_err_d = sym_bad;
      out_sym_d = sym_bad ? SYM_NONE : rel_sym;
    end else begin
      out_err_d = out_err_q;
      out_sym_d = out_sym_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q       <= SYM_W'(0);
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sym_q   <= SYM_NONE;
      out_err_q   <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.pos       = pos_q;
  assign bus.carry_out = carry_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sym   = out_sym_q;
  assign bus.out_err   = out_err_q;

endmodule
